// File: rtl/gate_vector_checker.sv
// gate_vector_checker: drives a/b through the 2-input truth table, compares the
// seven gate-block outputs against a local golden model and reports pass/fail,
// a saturating mismatch count and a sticky per-output failure mask.
// Optional build macro GATECHK_STOP_ON_FAIL_EN: stop the run at the first
// failing vector and report that vector on fail_vec.
module gate_vector_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             ny,
  input  logic             ay,
  input  logic             oy,
  input  logic             nay,
  input  logic             noy,
  input  logic             xoy,
  input  logic             xny,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       fail_mask
`ifdef GATECHK_STOP_ON_FAIL_EN
  ,
  output logic [1:0]       fail_vec
`endif
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int CW = ERR_W + 3;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] LAST_PASS   = PW'(NUM_PASSES - 1);
  localparam logic [CW-1:0] ERR_MAX     = {3'b000, {ERR_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t           state;
  logic [1:0]       vec_idx;
  logic [PW-1:0]    pass_idx;
  logic [SW-1:0]    settle_cnt;

  logic [6:0]       golden;
  logic [6:0]       observed;
  logic [6:0]       miss;
  logic [CW-1:0]    miss_cnt;
  logic [CW-1:0]    err_sum;
  logic [ERR_W-1:0] err_next;
  logic             last_vec;
  logic             stop_now;

  // Golden outputs for the current operands, mismatch bits and saturating count update
  always_comb begin
    golden   = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
    observed = {xny, xoy, noy, nay, oy, ay, ny};
    miss     = golden ^ observed;
    miss_cnt = '0;
    for (int i = 0; i < 7; i++) begin
      miss_cnt = miss_cnt + CW'(miss[i]);
    end
    err_sum = {3'b000, err_count} + miss_cnt;
    if (err_sum > ERR_MAX) begin
      err_next = {ERR_W{1'b1}};
    end else begin
      err_next = err_sum[ERR_W-1:0];
    end
    last_vec = (vec_idx == 2'd3) && (pass_idx == LAST_PASS);
`ifdef GATECHK_STOP_ON_FAIL_EN
    stop_now = last_vec || (|miss);
`else
    stop_now = last_vec;
`endif
  end

  // Sequencer: vector stepping, settle timing, sampling and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_mask  <= '0;
      vec_idx    <= '0;
      pass_idx   <= '0;
      settle_cnt <= '0;
`ifdef GATECHK_STOP_ON_FAIL_EN
      fail_vec   <= 2'b00;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SETTLE;
            vec_idx    <= 2'd0;
            pass_idx   <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            err_count  <= '0;
            fail_mask  <= '0;
            busy       <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
`ifdef GATECHK_STOP_ON_FAIL_EN
            fail_vec   <= 2'b00;
`endif
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        SAMPLE: begin
          err_count <= err_next;
          fail_mask <= fail_mask | miss;
          if (stop_now) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
`ifdef GATECHK_STOP_ON_FAIL_EN
            if (|miss) begin
              fail_vec <= {a, b};
            end
`endif
          end else begin
            state      <= SETTLE;
            vec_idx    <= vec_idx + 2'd1;
            {a, b}     <= vec_idx + 2'd1;
            settle_cnt <= SETTLE_LOAD;
            if (vec_idx == 2'd3) begin
              pass_idx <= pass_idx + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker: three checker instances with different parameter sets,
// each wrapped around a behavioural gate block with injectable stuck-at faults.
// Directed table rows, a mid-run reset sequence and randomized fault runs are
// checked against a truth-table reference model.
module tb_gate_vector_checker;

  localparam int NDUT = 3;
  localparam int S_P  [NDUT] = '{1, 1, 3};
  localparam int NP_P [NDUT] = '{1, 2, 3};
  localparam int E_P  [NDUT] = '{8, 2, 4};

  // Expected {xny,xoy,noy,nay,oy,ay,ny} for {a,b} = 00, 01, 10, 11
  localparam logic [6:0] TRUTH [4] = '{7'b1011001, 7'b0101101, 7'b0101100, 7'b1000110};

  typedef struct {
    int         k;
    logic [6:0] f0;
    logic [6:0] f1;
    int         err;
    logic [6:0] mask;
    logic       pss;
    int         cyc;
    logic [1:0] last;
    logic [1:0] fv;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s [NDUT];
  logic       a_s     [NDUT];
  logic       b_s     [NDUT];
  logic       busy_s  [NDUT];
  logic       done_s  [NDUT];
  logic       pass_s  [NDUT];
  logic [7:0] err_s   [NDUT];
  logic [6:0] mask_s  [NDUT];
  logic [1:0] fvec_s  [NDUT];
  logic [6:0] sa0     [NDUT];
  logic [6:0] sa1     [NDUT];

  int checks = 0;
  int passes = 0;

  // Free-running clock
  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    logic [6:0]        gate_out;
    logic [E_P[k]-1:0] err_w;
    logic [1:0]        fv_w;

    // Behavioural gate block with stuck-at-0 taking precedence over stuck-at-1
    always_comb begin
      gate_out = {~(a_s[k] ^ b_s[k]), a_s[k] ^ b_s[k], ~(a_s[k] | b_s[k]),
                  ~(a_s[k] & b_s[k]), a_s[k] | b_s[k], a_s[k] & b_s[k], ~a_s[k]};
      gate_out = (gate_out | sa1[k]) & ~sa0[k];
    end

    gate_vector_checker #(
      .SETTLE_CYCLES(S_P[k]),
      .NUM_PASSES   (NP_P[k]),
      .ERR_W        (E_P[k])
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_s[k]),
      .a        (a_s[k]),
      .b        (b_s[k]),
      .ny       (gate_out[0]),
      .ay       (gate_out[1]),
      .oy       (gate_out[2]),
      .nay      (gate_out[3]),
      .noy      (gate_out[4]),
      .xoy      (gate_out[5]),
      .xny      (gate_out[6]),
      .busy     (busy_s[k]),
      .done     (done_s[k]),
      .pass     (pass_s[k]),
      .err_count(err_w),
      .fail_mask(mask_s[k])
`ifdef GATECHK_STOP_ON_FAIL_EN
      ,
      .fail_vec (fv_w)
`endif
    );

`ifndef GATECHK_STOP_ON_FAIL_EN
    assign fv_w = 2'b00;
`endif
    assign err_s[k]  = 8'(err_w);
    assign fvec_s[k] = fv_w;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkReset(input int k);
    checkOutput($sformatf("rst_ctrl_%0d", k),
                {27'd0, a_s[k], b_s[k], busy_s[k], done_s[k], pass_s[k]}, 32'd0);
    checkOutput($sformatf("rst_err_%0d", k), {24'd0, err_s[k]}, 32'd0);
    checkOutput($sformatf("rst_mask_%0d", k), {25'd0, mask_s[k]}, 32'd0);
    checkOutput($sformatf("rst_fvec_%0d", k), {30'd0, fvec_s[k]}, 32'd0);
  endtask

  // Reference: walk every pass and vector, compare the faulty outputs with the truth table
  function automatic void model_run(input int k, input logic [6:0] f0, input logic [6:0] f1,
                                    output int err, output logic [6:0] mask, output logic pss,
                                    output int cyc, output logic [1:0] last, output logic [1:0] fv);
    int   sat;
    logic stop;
    sat  = (1 << E_P[k]) - 1;
    stop = 1'b0;
    err  = 0;
    mask = '0;
    cyc  = 0;
    last = 2'd3;
    fv   = 2'd0;
    for (int p = 0; p < NP_P[k]; p++) begin
      for (int v = 0; v < 4; v++) begin
        if (!stop) begin
          logic [6:0] seen;
          logic [6:0] diff;
          seen = (TRUTH[v] | f1) & ~f0;
          diff = seen ^ TRUTH[v];
          err  = err + $countones(diff);
          if (err > sat) err = sat;
          mask = mask | diff;
          cyc  = cyc + S_P[k] + 1;
`ifdef GATECHK_STOP_ON_FAIL_EN
          if (diff != 7'd0) begin
            stop = 1'b1;
            last = v[1:0];
            fv   = v[1:0];
          end
`endif
        end
      end
    end
    pss = (err == 0);
  endfunction

  task automatic applyStimulus(input vec_t t);
    int   edges;
    logic seen;
    logic [1:0] exp_ab;
    sa0[t.k] = t.f0;
    sa1[t.k] = t.f1;
    @(negedge clk);
    start_s[t.k] = 1'b1;
    @(posedge clk);
    #1;
    start_s[t.k] = 1'b0;
    checkOutput("accept_state", {28'd0, busy_s[t.k], done_s[t.k], a_s[t.k], b_s[t.k]}, 32'b1000);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < t.cyc + 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (done_s[t.k]) begin
        seen = 1'b1;
      end else begin
        exp_ab = 2'((edges / (S_P[t.k] + 1)) % 4);
        checkOutput("busy_ab_step", {29'd0, busy_s[t.k], a_s[t.k], b_s[t.k]}, {29'd0, 1'b1, exp_ab});
        start_s[t.k] = 1'($urandom_range(0, 1));
      end
    end
    start_s[t.k] = 1'b0;
    checkOutput("done_seen", {31'd0, seen}, 32'd1);
    checkOutput("run_edges", edges, t.cyc);
    checkOutput("done_busy_pass", {30'd0, busy_s[t.k], pass_s[t.k]}, {30'd0, 1'b0, t.pss});
    checkOutput("err_count", {24'd0, err_s[t.k]}, t.err);
    checkOutput("fail_mask", {25'd0, mask_s[t.k]}, {25'd0, t.mask});
    checkOutput("final_ab", {30'd0, a_s[t.k], b_s[t.k]}, {30'd0, t.last});
    checkOutput("fail_vec", {30'd0, fvec_s[t.k]}, {30'd0, t.fv});
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", {30'd0, done_s[t.k], busy_s[t.k]}, 32'd0);
    checkOutput("result_hold", {16'd0, err_s[t.k], 1'b0, mask_s[t.k]}, {16'd0, 8'(t.err), 1'b0, t.mask});
    @(posedge clk);
    #1;
    checkOutput("no_second_run", {31'd0, busy_s[t.k]}, 32'd0);
  endtask

  initial begin
    vec_t dir [5];
    vec_t r;
    logic quiet;

`ifdef GATECHK_STOP_ON_FAIL_EN
    dir[0] = '{0, 7'h00, 7'h00, 0, 7'h00, 1'b1, 8,  2'd3, 2'd0};
    dir[1] = '{0, 7'h20, 7'h00, 1, 7'h20, 1'b0, 4,  2'd1, 2'd1};
    dir[2] = '{1, 7'h7f, 7'h00, 3, 7'h59, 1'b0, 2,  2'd0, 2'd0};
    dir[3] = '{0, 7'h00, 7'h01, 1, 7'h01, 1'b0, 6,  2'd2, 2'd2};
    dir[4] = '{2, 7'h00, 7'h00, 0, 7'h00, 1'b1, 48, 2'd3, 2'd0};
`else
    dir[0] = '{0, 7'h00, 7'h00, 0, 7'h00, 1'b1, 8,  2'd3, 2'd0};
    dir[1] = '{0, 7'h20, 7'h00, 2, 7'h20, 1'b0, 8,  2'd3, 2'd0};
    dir[2] = '{1, 7'h7f, 7'h00, 3, 7'h7f, 1'b0, 16, 2'd3, 2'd0};
    dir[3] = '{0, 7'h00, 7'h01, 2, 7'h01, 1'b0, 8,  2'd3, 2'd0};
    dir[4] = '{2, 7'h00, 7'h00, 0, 7'h00, 1'b1, 48, 2'd3, 2'd0};
`endif

    for (int k = 0; k < NDUT; k++) begin
      start_s[k] = 1'b0;
      sa0[k]     = '0;
      sa1[k]     = '0;
    end

    // Power-on reset then idle
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) checkReset(k);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      $display("[TB] directed row %0d on instance %0d", i, dir[i].k);
      applyStimulus(dir[i]);
    end

    // Reset during vector 10 on the default instance
    sa0[0] = '0;
    sa1[0] = '0;
    @(negedge clk);
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("mid_run_ab", {30'd0, a_s[0], b_s[0]}, 32'b10);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) checkReset(k);
    @(negedge clk);
    rst   = 1'b0;
    quiet = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done_s[0] || busy_s[0]) quiet = 1'b0;
    end
    checkOutput("rst_no_done", {31'd0, quiet}, 32'd1);
    applyStimulus(dir[0]);

    // Randomized fault runs
    for (int i = 0; i < 24; i++) begin
      r.k = $urandom_range(0, NDUT - 1);
      if ($urandom_range(0, 3) == 0) begin
        r.f0 = '0;
        r.f1 = '0;
      end else begin
        r.f0 = 7'($urandom) & 7'($urandom);
        r.f1 = 7'($urandom) & 7'($urandom) & ~r.f0;
      end
      model_run(r.k, r.f0, r.f1, r.err, r.mask, r.pss, r.cyc, r.last, r.fv);
      applyStimulus(r);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
